multiport_stream_serializer: RTL

- Read-side companion to the team's multi-port FIFO.
- Accepts a burst of up to LANES words per cycle from parallel read ports and buffers them in a circular store.
- Emits the words one per cycle on a single ready/valid stream, lane 0 first.
- Sits between a multi-read-port FIFO and any single-word consumer.

---
 rtl/multiport_stream_serializer.sv | 111 +++++++++++
 1 files changed

// File: rtl/multiport_stream_serializer.sv
// multiport_stream_serializer
// Takes bursts of up to LANES words per cycle from parallel FIFO read ports,
// buffers them in a circular store and replays them one word per cycle on a
// first-word-fall-through ready/valid stream, lane 0 of each burst first.

module multiport_stream_serializer #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int DEPTH = 16
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic [WIDTH*LANES-1:0]       in_data,
    input  logic [$clog2(LANES+1)-1:0]   in_count,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [$clog2(DEPTH):0]       level,
    output logic                         err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(LANES + 1);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [LW-1:0]    level_r;
    logic             err_r;

    logic             push_s;
    logic             bad_count_s;
    logic             pop_s;
    logic [LW-1:0]    add_s;
    logic [LW-1:0]    sub_s;
    logic [LANES-1:0] lane_we_s;

    // Space for a whole burst is judged from the stored level alone, so the
    // producer never sees a combinational path from its own valid/count.
    assign in_ready  = (LW'(DEPTH) - level_r) >= LW'(LANES);
    assign out_valid = (level_r != {LW{1'b0}});
    assign out_data  = mem_r[rd_ptr_r];
    assign level     = level_r;
    assign err       = err_r;

    // Classify the handshake and build the per-lane write enables.
    always_comb begin
        push_s      = 1'b0;
        bad_count_s = 1'b0;
        pop_s       = out_valid && out_ready;
        add_s       = {LW{1'b0}};
        sub_s       = {LW{1'b0}};
        lane_we_s   = {LANES{1'b0}};
        if (in_valid && in_ready) begin
            if (in_count <= CW'(LANES)) begin
                push_s = 1'b1;
                add_s  = LW'(in_count);
            end else begin
                bad_count_s = 1'b1;
            end
        end else begin
            push_s = 1'b0;
        end
        if (pop_s) begin
            sub_s = LW'(1);
        end else begin
            sub_s = {LW{1'b0}};
        end
        for (int i = 0; i < LANES; i++) begin
            if (push_s && (CW'(i) < in_count)) begin
                lane_we_s[i] = 1'b1;
            end else begin
                lane_we_s[i] = 1'b0;
            end
        end
    end

    // Burst storage: valid lanes land in consecutive slots from wr_ptr, wrapping.
    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++) begin
            if (lane_we_s[i]) begin
                mem_r[wr_ptr_r + PW'(i)] <= in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Pointers, occupancy and the sticky illegal-count flag; reset wins over traffic.
    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            level_r  <= {LW{1'b0}};
            err_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(in_count);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PW'(1);
            end
            level_r <= level_r + add_s - sub_s;
            if (bad_count_s) begin
                err_r <= 1'b1;
            end
        end
    end

endmodule
